// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and
// clocks one command byte (LSB first, odd parity, stop) out under device clocking.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 250,
    parameter int TIMEOUT_CYCLES = 31200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, START, DATA, PARITY, STOP, ACK_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          clk_s, data_s, fall;

    // Synchronisers reset to the idle (pulled-up) level so no spurious fall follows reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    assign tx_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rx_inhibit = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: if (tx_valid) begin
                    shreg       <= tx_data;
                    parity      <= ~^tx_data;
                    bitcnt      <= '0;
                    cnt         <= '0;
                    ps2_clk_oe  <= 1'b1;
                    ps2_data_oe <= 1'b0;
                    state       <= INHIBIT;
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    state      <= START;
                end
                default: begin
                    // Timeout is checked ahead of any bus edge so it always wins
                    if (cnt == TO_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
                        case (state)
                            START: if (fall) begin
                                ps2_data_oe <= ~shreg[0];
                                shreg       <= {1'b0, shreg[7:1]};
                                bitcnt      <= '0;
                                state       <= DATA;
                            end
                            DATA: if (fall) begin
                                if (bitcnt == 3'd7) begin
                                    ps2_data_oe <= ~parity;
                                    state       <= PARITY;
                                end else begin
                                    ps2_data_oe <= ~shreg[0];
                                    shreg       <= {1'b0, shreg[7:1]};
                                    bitcnt      <= bitcnt + 1'b1;
                                end
                            end
                            PARITY: if (fall) begin
                                ps2_data_oe <= 1'b0;
                                state       <= STOP;
                            end
                            STOP: if (fall) begin
                                if (data_s) begin
                                    tx_err <= 1'b1;
                                    state  <= IDLE;
                                end else begin
                                    state  <= ACK_WAIT;
                                end
                            end
                            ACK_WAIT: if (clk_s && data_s) begin
                                tx_done <= 1'b1;
                                state   <= IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural keyboard clocks frames at ~12.5 kHz
// over a wired-AND bus and the captured wire bits are checked against literals.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int HALF = 40000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy, rx_inhibit;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    wire        ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    wire        ps2_data_in = ~(ps2_data_oe | dev_data_low);

    int checks = 0, errors = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;

    ps2_host_tx dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
        .rx_inhibit(rx_inhibit), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #240 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pulse(output logic seen);
        dev_clk_low = 1'b1;
        #HALF;
        seen = ps2_data_in;
        dev_clk_low = 1'b0;
        #HALF;
    endtask

    // Inhibit (250) plus REQ (1) cycles of clock held low, then the start bit on the wire
    task automatic frame_front(input string tag);
        int n;
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_inhibit_len"}, n, 251);
        chk({tag, "_start_bit"}, ps2_data_in, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_rx_inhibit"}, rx_inhibit, 1'b1);
        chk({tag, "_ready_low"}, tx_ready, 1'b0);
    endtask

    task automatic do_frame(input string tag, input logic [9:0] exp_bits, input logic ack);
        int d0, e0, n;
        logic [9:0] cap;
        logic s;
        d0 = done_cnt;
        e0 = err_cnt;
        frame_front(tag);
        #HALF;
        for (int i = 0; i < 10; i++) begin
            pulse(s);
            cap[i] = s;
        end
        if (ack) dev_data_low = 1'b1;
        pulse(s);
        dev_data_low = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        #1;
        chk({tag, "_wire_bits"}, cap, exp_bits);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_done_cnt"}, done_cnt - d0, ack ? 1 : 0);
        chk({tag, "_err_cnt"}, err_cnt - e0, ack ? 0 : 1);
        chk({tag, "_clk_rel"}, ps2_clk_oe, 1'b0);
        chk({tag, "_data_rel"}, ps2_data_oe, 1'b0);
    endtask

    initial begin
        logic s;
        int n, m;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_inh", rx_inhibit, 1'b0);
        chk("rst_done_err", {tx_done, tx_err}, 2'b00);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        start_tx(8'hED);
        do_frame("ed", 10'b1_1_11101101, 1'b1);
        start_tx(8'h00);
        do_frame("x00", 10'b1_1_00000000, 1'b1);
        start_tx(8'hFF);
        do_frame("xff", 10'b1_1_11111111, 1'b1);
        start_tx(8'h01);
        do_frame("x01", 10'b1_0_00000001, 1'b1);

        // Device clocks all 11 but never acks
        start_tx(8'h12);
        do_frame("noack", 10'b1_1_00010010, 1'b0);

        // Device never clocks: error lands TIMEOUT_CYCLES after leaving REQ
        start_tx(8'h55);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        m = 0;
        while (tx_err !== 1'b1 && m < 40000) begin
            m++;
            @(negedge clk);
        end
        chk("timeout_len", m, 31200);
        chk("timeout_clk_rel", ps2_clk_oe, 1'b0);
        chk("timeout_data_rel", ps2_data_oe, 1'b0);
        chk("timeout_idle", busy, 1'b0);
        repeat (3) @(negedge clk);

        // Reset while bit4 (0 for 0xED) is on the wire
        start_tx(8'hED);
        frame_front("rstmid");
        #HALF;
        for (int i = 0; i < 4; i++) pulse(s);
        dev_clk_low = 1'b1;
        #(HALF / 2);
        chk("rstmid_bit4_drive", ps2_data_oe, 1'b1);
        @(negedge clk);
        #100;
        reset = 1'b1;
        #1;
        chk("rstmid_clk_oe", ps2_clk_oe, 1'b0);
        chk("rstmid_data_oe", ps2_data_oe, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_ready", tx_ready, 1'b1);
        dev_clk_low = 1'b0;
        #1000;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        start_tx(8'hF4);
        do_frame("f4", 10'b1_0_11110100, 1'b1);

        // 0xAA held valid through the 0xED transfer; only taken once IDLE returns
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'hAA;
        do_frame("hold_ed", 10'b1_1_11101101, 1'b1);
        chk("hold_ready", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        do_frame("hold_aa", 10'b1_1_10101010, 1'b1);

        chk("done_err_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
